countdown_timer: RTL and testbench

- BCD MM:SS countdown timer that feeds the magnetron control logic.
- Accepts keypad digits, shifted in from the right in microwave style, while the magnetron is off.
- Counts down once per second while the magnetron is on.
- Drives timer_done, which the magnetron logic uses to force the latch to reset.
- Also drives a one-cycle done pulse and an alarm level for the beeper/display path.

---
 rtl/countdown_timer.sv | 198 +++++++++++++++++++
 tb/tb_countdown_timer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: BCD MM:SS countdown for the magnetron control path.
// Keypad digits shift in from the right while the magnetron is off. While it
// is on, the time counts down once per TICK_DIV clocks. timer_done tells the
// magnetron logic to drop its latch, and done_pulse/alarm feed the beeper.
module countdown_timer #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       enable,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic [3:0] mm_tens,
  output logic [3:0] mm_ones,
  output logic [3:0] ss_tens,
  output logic [3:0] ss_ones,
  output logic       timer_done,
  output logic       done_pulse,
  output logic       alarm
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ZERO = PW'(32'd0);
  localparam logic [PW-1:0] PRE_ONE  = PW'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RUNNING  = 2'd2,
    ST_FINISHED = 2'd3
  } state_t;

  // Time is held as four packed BCD digits {mm_tens, mm_ones, ss_tens, ss_ones}.
  state_t         state_r;
  state_t         state_s;
  logic [15:0]    time_r;
  logic [15:0]    time_s;
  logic [PW-1:0]  pre_r;
  logic [PW-1:0]  pre_s;
  logic           timer_done_r;
  logic           timer_done_s;
  logic           done_pulse_r;
  logic           done_pulse_s;
  logic           alarm_r;
  logic           alarm_s;

  logic           run_s;
  logic           tick_s;
  logic           key_ok_s;
  logic [15:0]    shifted_s;
  logic [15:0]    dec_s;

  // One-second BCD decrement with borrow from seconds into minutes.
  // Entered seconds may exceed 59, so ss_tens just counts down like any digit.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else if (t[7:4] != 4'd0) begin
      r[7:4] = t[7:4] - 4'd1;
      r[3:0] = 4'd9;
    end else begin
      r[7:0] = 8'h59;
      if (t[11:8] != 4'd0) begin
        r[11:8] = t[11:8] - 4'd1;
      end else begin
        r[11:8]  = 4'd9;
        r[15:12] = t[15:12] - 4'd1;
      end
    end
    return r;
  endfunction

  // Qualify the tick and key events that the next-state logic arbitrates.
  always_comb begin
    run_s     = 1'b0;
    tick_s    = 1'b0;
    key_ok_s  = 1'b0;
    shifted_s = {time_r[11:0], key_digit};
    dec_s     = bcd_dec(time_r);
    // The prescaler runs on any edge where enable is high and there is time
    // left, including the edge that moves ARMED into RUNNING.
    if (enable && (time_r != 16'd0) &&
        ((state_r == ST_ARMED) || (state_r == ST_RUNNING))) begin
      run_s = 1'b1;
    end else begin
      run_s = 1'b0;
    end
    if (run_s && (pre_r == PRE_LAST)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
    if (key_valid && !enable && (key_digit <= 4'd9)) begin
      key_ok_s = 1'b1;
    end else begin
      key_ok_s = 1'b0;
    end
  end

  // Next state, time and prescaler. Priority is clear, then tick, then key.
  always_comb begin
    state_s      = state_r;
    time_s       = time_r;
    pre_s        = pre_r;
    done_pulse_s = 1'b0;
    if (!clearn) begin
      state_s = ST_IDLE;
      time_s  = 16'd0;
      pre_s   = PRE_ZERO;
    end else if (tick_s) begin
      time_s = dec_s;
      pre_s  = PRE_ZERO;
      if (dec_s == 16'd0) begin
        state_s      = ST_FINISHED;
        done_pulse_s = 1'b1;
      end else begin
        state_s = ST_RUNNING;
      end
    end else if (key_ok_s) begin
      time_s = shifted_s;
      if (shifted_s != 16'd0) begin
        state_s = ST_ARMED;
      end else if (state_r == ST_FINISHED) begin
        // A zero key at 00:00 changes nothing, so the alarm stays up.
        state_s = ST_FINISHED;
        pre_s   = PRE_ZERO;
      end else begin
        state_s = ST_IDLE;
        pre_s   = PRE_ZERO;
      end
    end else begin
      if (run_s) begin
        pre_s = pre_r + PRE_ONE;
      end else begin
        pre_s = pre_r;
      end
      case (state_r)
        ST_IDLE:     state_s = ST_IDLE;
        ST_ARMED:    state_s = enable ? ST_RUNNING : ST_ARMED;
        ST_RUNNING:  state_s = enable ? ST_RUNNING : ST_ARMED;
        ST_FINISHED: state_s = ST_FINISHED;
        default: begin
          state_s = ST_IDLE;
          time_s  = 16'd0;
          pre_s   = PRE_ZERO;
        end
      endcase
    end
  end

  // Status flags follow the next time/state so they land on the same edge.
  always_comb begin
    timer_done_s = 1'b0;
    alarm_s      = 1'b0;
    if (time_s == 16'd0) begin
      timer_done_s = 1'b1;
    end else begin
      timer_done_s = 1'b0;
    end
    if (state_s == ST_FINISHED) begin
      alarm_s = 1'b1;
    end else begin
      alarm_s = 1'b0;
    end
  end

  // State, time, prescaler and output flag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      time_r       <= 16'd0;
      pre_r        <= PRE_ZERO;
      timer_done_r <= 1'b1;
      done_pulse_r <= 1'b0;
      alarm_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      time_r       <= time_s;
      pre_r        <= pre_s;
      timer_done_r <= timer_done_s;
      done_pulse_r <= done_pulse_s;
      alarm_r      <= alarm_s;
    end
  end

  assign mm_tens    = time_r[15:12];
  assign mm_ones    = time_r[11:8];
  assign ss_tens    = time_r[7:4];
  assign ss_ones    = time_r[3:0];
  assign timer_done = timer_done_r;
  assign done_pulse = done_pulse_r;
  assign alarm      = alarm_r;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench for countdown_timer with TICK_DIV=4.
// The reference model keeps the time as a plain decimal number MMSS and
// counts clock edges toward a tick; expected outputs are queued per edge and
// popped by a negedge monitor.
module tb_countdown_timer;

  localparam int TD = 4;

  logic       clk;
  logic       resetn;
  logic       clearn;
  logic       enable;
  logic       key_valid;
  logic [3:0] key_digit;
  logic [3:0] mm_tens;
  logic [3:0] mm_ones;
  logic [3:0] ss_tens;
  logic [3:0] ss_ones;
  logic       timer_done;
  logic       done_pulse;
  logic       alarm;

  countdown_timer #(.TICK_DIV(TD)) dut (
    .clk(clk), .resetn(resetn), .clearn(clearn), .enable(enable),
    .key_valid(key_valid), .key_digit(key_digit),
    .mm_tens(mm_tens), .mm_ones(mm_ones), .ss_tens(ss_tens), .ss_ones(ss_ones),
    .timer_done(timer_done), .done_pulse(done_pulse), .alarm(alarm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // model state: time as decimal MMSS, edges since last tick, alarm, pulse
  int m_val = 0;
  int m_pre = 0;
  bit m_fin = 1'b0;
  bit m_pulse = 1'b0;
  bit rn_drive = 1'b0;

  logic [18:0] exp_q[$];

  function automatic logic [18:0] model_out();
    logic [15:0] d;
    d[15:12] = 4'((m_val / 1000) % 10);
    d[11:8]  = 4'((m_val / 100) % 10);
    d[7:4]   = 4'((m_val / 10) % 10);
    d[3:0]   = 4'(m_val % 10);
    return {d, (m_val == 0), m_pulse, m_fin};
  endfunction

  function automatic logic [18:0] dut_out();
    return {mm_tens, mm_ones, ss_tens, ss_ones, timer_done, done_pulse, alarm};
  endfunction

  task automatic model_reset();
    m_val = 0; m_pre = 0; m_fin = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_edge(input bit rn, input bit cl, input bit en,
                            input bit kv, input logic [3:0] kd);
    if (!rn || !cl) begin
      model_reset();
    end else if (en && m_val != 0) begin
      m_pulse = 1'b0;
      m_pre = m_pre + 1;
      if (m_pre == TD) begin
        m_pre = 0;
        if (m_val % 100 > 0) m_val = m_val - 1;
        else m_val = m_val - 100 + 59;
        if (m_val == 0) begin
          m_fin = 1'b1;
          m_pulse = 1'b1;
        end
      end
    end else begin
      m_pulse = 1'b0;
      if (kv && !en && kd <= 4'd9) begin
        m_val = (m_val * 10 + int'(kd)) % 10000;
        if (m_val != 0) m_fin = 1'b0;
        else m_pre = 0;
      end
    end
  endtask

  task automatic check(input string nm, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got time=%h done=%b pulse=%b alarm=%b, expected time=%h done=%b pulse=%b alarm=%b",
               nm, act[18:3], act[2], act[1], act[0], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Monitor: compare the DUT against the expectation queued at the last edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      check("scoreboard", dut_out(), exp_q.pop_front());
    end
  end

  task automatic step(input bit en, input bit kv, input logic [3:0] kd, input bit cl);
    @(negedge clk);
    resetn = rn_drive; enable = en; key_valid = kv; key_digit = kd; clearn = cl;
    @(posedge clk);
    model_edge(rn_drive, cl, en, kv, kd);
    exp_q.push_back(model_out());
  endtask

  task automatic key(input logic [3:0] kd);
    step(1'b0, 1'b1, kd, 1'b1);
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) step(en, 1'b0, 4'd0, 1'b1);
  endtask

  task automatic clear();
    step(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic spot(input string nm, input logic [15:0] d, input bit td,
                      input bit dp, input bit al);
    #1;
    check(nm, dut_out(), {d, td, dp, al});
  endtask

  initial begin
    resetn = 1'b0; clearn = 1'b1; enable = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    rn_drive = 1'b0;
    run(2, 1'b0);
    spot("reset", 16'h0000, 1'b1, 1'b0, 1'b0);
    rn_drive = 1'b1;

    // keypad entry and out-of-range digit
    key(4'd1); key(4'd3); key(4'd0);
    spot("keys_0130", 16'h0130, 1'b0, 1'b0, 1'b0);
    key(4'd12);
    spot("key12_ignored", 16'h0130, 1'b0, 1'b0, 1'b0);
    clear();

    // 00:02 runs out; done pulse and alarm
    key(4'd0); key(4'd2);
    run(4, 1'b1);
    spot("after4_0001", 16'h0001, 1'b0, 1'b0, 1'b0);
    run(4, 1'b1);
    spot("done_0000", 16'h0000, 1'b1, 1'b1, 1'b1);
    run(3, 1'b0);
    spot("alarm_held", 16'h0000, 1'b1, 1'b0, 1'b1);
    clear();
    spot("alarm_cleared", 16'h0000, 1'b1, 1'b0, 1'b0);

    // minute borrow
    key(4'd1); key(4'd0); key(4'd0);
    run(4, 1'b1);
    spot("borrow_0059", 16'h0059, 1'b0, 1'b0, 1'b0);
    clear();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    run(4, 1'b1);
    spot("borrow_0959", 16'h0959, 1'b0, 1'b0, 1'b0);
    clear();

    // pause keeps the partial second; keys ignored while running
    key(4'd5);
    step(1'b1, 1'b1, 4'd7, 1'b1);
    step(1'b1, 1'b1, 4'd8, 1'b1);
    run(10, 1'b0);
    run(2, 1'b1);
    spot("pause_0004", 16'h0004, 1'b0, 1'b0, 1'b0);
    clear();

    // clear on a tick edge wins
    key(4'd3);
    run(3, 1'b1);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    spot("clear_on_tick", 16'h0000, 1'b1, 1'b0, 1'b0);
    run(6, 1'b1);
    spot("idle_no_count", 16'h0000, 1'b1, 1'b0, 1'b0);
    clear();

    // asynchronous reset mid-run
    key(4'd4); key(4'd0);
    run(3, 1'b1);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    rn_drive = 1'b0;
    #1;
    check("async_reset", dut_out(), {16'h0000, 1'b1, 1'b0, 1'b0});
    model_reset();
    run(2, 1'b1);
    rn_drive = 1'b1;
    run(6, 1'b1);
    spot("post_reset_idle", 16'h0000, 1'b1, 1'b0, 1'b0);

    // randomized episodes: short times, mostly enabled, stray keys
    for (int ep = 0; ep < 12; ep++) begin
      clear();
      key(4'($urandom_range(0, 9)));
      key(4'($urandom_range(0, 9)));
      for (int i = 0; i < 100; i++) begin
        bit en;
        bit kv;
        logic [3:0] kd;
        bit cl;
        en = ($urandom_range(0, 4) != 0);
        kv = ($urandom_range(0, 5) == 0);
        kd = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
        cl = ($urandom_range(0, 149) != 0);
        step(en, kv, kd, cl);
      end
    end

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
